key_pulse_bank: RTL and testbench

Parametrised multi-channel key conditioner that sits between the board push-buttons and the game-control logic. For each channel it synchronises the raw key, debounces it, and produces a debounced level plus single-cycle press and release pulses. Each channel also has an optional per-channel auto-repeat mode that re-issues press pulses while the key is held. All channels are independent and share one clock and reset.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_pulse_bank_if.sv | 29 ++
 rtl/key_channel.sv | 130 +++++++++++++
 rtl/key_pulse_bank.sv | 41 ++++
 tb/tb_key_pulse_bank.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types for the key conditioner: per-channel FSM states and a small
// helper used to size the repeat counter.
package key_pkg;

    typedef enum logic [1:0] {
        K_RELEASED,
        K_HELD,
        K_DELAY,
        K_REPEAT
    } key_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_pulse_bank_if.sv
// Key bank bus: raw keys and repeat enables in, conditioned level/pulses out.
// The release pulse is called release_pulse because `release` is reserved.
interface key_pulse_bank_if #(
    parameter int N_KEYS = 4
);

    logic [N_KEYS-1:0] keys_in;
    logic [N_KEYS-1:0] repeat_en;
    logic [N_KEYS-1:0] held;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] release_pulse;

    modport master (
        output keys_in,
        output repeat_en,
        input  held,
        input  press,
        input  release_pulse
    );

    modport slave (
        input  keys_in,
        input  repeat_en,
        output held,
        output press,
        output release_pulse
    );

endinterface

// File: rtl/key_channel.sv
// One key channel: synchroniser, debouncer, and press/repeat/release FSM.
// Every output is a flop, so nothing reaches the outputs combinationally.
module key_channel
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 8,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic key_in,
    input  logic repeat_en,
    output logic held,
    output logic press,
    output logic release_pulse
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_END = RCW'(REPEAT_DELAY);
    localparam logic [RCW-1:0] RATE_END  = RCW'(REPEAT_RATE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    logic [DBW-1:0]         db_cnt;
    logic                   accept;
    logic                   press_evt;
    logic                   release_evt;

    key_state_t     state, state_n;
    logic [RCW-1:0] rpt_cnt, rpt_cnt_n, rpt_inc;
    logic           press_n, release_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INACTIVE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
        end
    end

    assign act = sync_q[SYNC_STAGES-1] ^ INACTIVE;

    // The change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept      = (act != held) && (db_cnt == DB_LAST);
    assign press_evt   = accept && !held;
    assign release_evt = accept && held;

    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt <= '0;
            held   <= 1'b0;
        end else begin
            if (act == held || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
            if (accept) begin
                held <= ~held;
            end
        end
    end

    assign rpt_inc = rpt_cnt + RCW'(1);

    // A release always takes precedence over a repeat falling due in the same cycle.
    always_comb begin
        state_n   = state;
        rpt_cnt_n = rpt_cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            K_RELEASED: begin
                if (press_evt) begin
                    press_n   = 1'b1;
                    rpt_cnt_n = '0;
                    state_n   = repeat_en ? K_DELAY : K_HELD;
                end
            end
            K_HELD: begin
                if (release_evt) begin
                    release_n = 1'b1;
                    rpt_cnt_n = '0;
                    state_n   = K_RELEASED;
                end
            end
            K_DELAY, K_REPEAT: begin
                if (release_evt) begin
                    release_n = 1'b1;
                    rpt_cnt_n = '0;
                    state_n   = K_RELEASED;
                end else if (!repeat_en) begin
                    rpt_cnt_n = '0;
                    state_n   = K_HELD;
                end else if (rpt_inc == ((state == K_DELAY) ? DELAY_END : RATE_END)) begin
                    press_n   = 1'b1;
                    rpt_cnt_n = '0;
                    state_n   = K_REPEAT;
                end else begin
                    rpt_cnt_n = rpt_inc;
                end
            end
            default: begin
                rpt_cnt_n = '0;
                state_n   = K_RELEASED;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= K_RELEASED;
            rpt_cnt       <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            rpt_cnt       <= rpt_cnt_n;
            press         <= press_n;
            release_pulse <= release_n;
        end
    end

endmodule

// File: rtl/key_pulse_bank.sv
// Bank of independent key channels sharing one clock and reset.
module key_pulse_bank #(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 8,
    parameter int ACTIVE_LOW      = 1
) (
    input logic clock,
    input logic reset,
    key_pulse_bank_if.slave bus
);

    logic [N_KEYS-1:0] held_w;
    logic [N_KEYS-1:0] press_w;
    logic [N_KEYS-1:0] release_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .key_in       (bus.keys_in[i]),
            .repeat_en    (bus.repeat_en[i]),
            .held         (held_w[i]),
            .press        (press_w[i]),
            .release_pulse(release_w[i])
        );
    end

    assign bus.held          = held_w;
    assign bus.press         = press_w;
    assign bus.release_pulse = release_w;

endmodule

// File: tb/tb_key_pulse_bank.sv
// Scenario bench for key_pulse_bank at default parameters; expected
// held/press/release vectors are queued per edge and compared #1 after it.
module tb_key_pulse_bank;

    typedef logic [11:0] exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    key_pulse_bank_if #(.N_KEYS(4)) bus ();

    key_pulse_bank dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic reset_idle();
        bus.keys_in   = 4'hF;
        bus.repeat_en = 4'h0;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t exp, got;
        bus.keys_in   = 4'h0;
        bus.repeat_en = 4'h0;
        reset         = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            sb.push_back(12'h000);
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL reset_hold edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            sb.push_back({(e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0});
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL reset_redetect edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
    endtask

    task automatic test_single_press();
        exp_t exp, got;
        logic h, p, r;
        reset_idle();
        for (int e = 1; e <= 24; e++) begin
            bus.keys_in = (e <= 10) ? 4'b1110 : 4'b1111;
            h = (e >= 6 && e < 16);
            p = (e == 6);
            r = (e == 16);
            sb.push_back({3'b000, h, 3'b000, p, 3'b000, r});
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL single_press edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
    endtask

    task automatic test_bounce();
        exp_t exp, got;
        reset_idle();
        for (int e = 1; e <= 14; e++) begin
            bus.keys_in = (e inside {1, 2, 3, 5, 6}) ? 4'b1101 : 4'b1111;
            sb.push_back(12'h000);
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL bounce edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
    endtask

    task automatic test_auto_repeat();
        exp_t exp, got;
        logic h, p, r;
        reset_idle();
        bus.repeat_en = 4'b0100;
        for (int e = 1; e <= 70; e++) begin
            bus.keys_in = (e <= 60) ? 4'b1011 : 4'b1111;
            h = (e >= 6 && e < 66);
            p = (e inside {6, 26, 34, 42, 50, 58});
            r = (e == 66);
            sb.push_back({1'b0, h, 2'b00, 1'b0, p, 2'b00, 1'b0, r, 2'b00});
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL auto_repeat edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t exp, got;
        logic [3:0] h, p;
        reset_idle();
        for (int e = 1; e <= 45; e++) begin
            bus.keys_in   = 4'b0011;
            bus.repeat_en = (e < 30) ? 4'b1000 : 4'b0000;
            h = (e >= 6) ? 4'b1100 : 4'b0000;
            p = {(e == 6 || e == 26), (e == 6), 2'b00};
            sb.push_back({h, p, 4'h0});
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL back_to_back edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t exp, got;
        logic h, p;
        reset_idle();
        bus.repeat_en = 4'b0001;
        bus.keys_in   = 4'b1110;
        for (int e = 1; e <= 42; e++) begin
            reset = (e >= 40);
            h = (e >= 6 && e < 40);
            p = (e inside {6, 26, 34});
            sb.push_back({3'b000, h, 3'b000, p, 4'h0});
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL reset_mid edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            h = (e >= 6);
            p = (e == 6);
            sb.push_back({3'b000, h, 3'b000, p, 4'h0});
            @(posedge clock); #1;
            exp = sb.pop_front();
            got = {bus.held, bus.press, bus.release_pulse};
            total++;
            if (got !== exp) $display("[TB] FAIL reset_mid_redetect edge %0d: got %h want %h", e, got, exp);
            else passed++;
        end
    endtask

    initial begin
        bus.keys_in   = 4'hF;
        bus.repeat_en = 4'h0;
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
